cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Shares the single cacheline-wide physical-memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two L1 caches on the pipelined CPU's split inst/data paths and main memory.
- Serialises requests through a 3-state FSM with round-robin tie-breaking, so neither the IF nor the MEM stage can be starved.

Parameters:
- ADDR_W, 32, address width in bits.
- LINE_W, 256, cacheline width in bits. Offset bits OFS = log2(LINE_W/8), 5 at default.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_read  in  1  icache line-read request, level-held until i_resp
- i_addr  in  ADDR_W  icache line address
- i_rdata  out  LINE_W  icache read data
- i_resp  out  1  icache completion pulse
- d_read  in  1  dcache line-read request, level-held until d_resp
- d_write  in  1  dcache line-write request, level-held until d_resp
- d_addr  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  dcache write data
- d_rdata  out  LINE_W  dcache read data
- d_resp  out  1  dcache completion pulse
- m_read  out  1  memory read command
- m_write  out  1  memory write command
- m_addr  out  ADDR_W  memory address, line-aligned
- m_wdata  out  LINE_W  memory write data
- m_rdata  in  LINE_W  memory read data
- m_resp  in  1  memory completion, one-cycle pulse

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=I.
  - m_read=0, m_write=0, m_addr=0, m_wdata=0, i_resp=0, d_resp=0.
  - i_rdata and d_rdata are continuous pass-throughs of m_rdata in all states, including reset.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Only i_read pending -> SERVE_I.
  - Only d_read or d_write pending -> SERVE_D.
  - Both pending -> grant the requester not equal to last_grant. The first tie after reset goes to D.
  - On the transition edge, register m_addr = {req_addr[ADDR_W-1:OFS], OFS'b0}.
  - For D writes, register m_wdata = d_wdata; reads leave m_wdata unchanged.
  - Register m_read or m_write; update last_grant.
- SERVE_I: m_read=1 held; m_write=0.
- SERVE_D:
  - m_write=1 if d_write was sampled at grant, else m_read=1.
  - d_write has priority if d_read and d_write are both high (protocol error, write wins).
- Address and data are latched at grant. Requester address/data changes during service are ignored.
- Completion, in SERVE_x with m_resp=1:
  - x_resp=1 in the same cycle (combinational from m_resp and state).
  - Data is valid on x_rdata in that cycle.
  - Next edge: state -> IDLE, m_read and m_write -> 0, m_addr and m_wdata hold.
- Latency:
  - Request seen in IDLE at cycle N -> m_read/m_write high at cycle N+1.
  - Earliest x_resp is at N+1 (if m_resp arrives immediately).
  - At least one IDLE cycle follows every transaction. The requester must drop its request the cycle after resp, so no duplicate grant occurs.
- Other rules:
  - m_resp in IDLE is ignored; no resp is pulsed.
  - Requester deasserts its request mid-service: the transaction still runs to m_resp, x_resp is still pulsed, and the requester ignores it.
  - The non-granted requester waits with its request held. Its resp stays 0; i_resp and d_resp are never high together.
- Reset mid-transaction: immediate return to reset values. The in-flight memory command is abandoned, and a late m_resp after reset is ignored.
- Implementation: no combinational path from request inputs to m_* outputs; all m_* outputs are registered.

Test Plan:
- Lone I read: i_read=1, i_addr=0x0000_1234 at cycle 0; memory responds 3 cycles after m_read with 0xAA..AA.
  -> m_read=1, m_addr=0x0000_1220 from cycle 1.
  -> i_resp pulses one cycle with i_rdata=0xAA..AA, d_resp=0.
  -> m_read=0 the following cycle.
- Lone D write: d_write=1, d_addr=0x8000_003C, d_wdata=0x5555..55.
  -> m_write=1, m_addr=0x8000_0020, m_wdata=0x5555..55.
  -> d_resp pulses with m_resp, m_read never asserts.
- Tie and round-robin: i_read and d_read both high from cycle 0 after reset, 2-cycle memory.
  -> D served first, then IDLE, then I served.
  -> Repeat the tie: I is served first (last_grant=D).
- Contention hold: D in service when i_read rises mid-transaction.
  -> i_resp stays 0 until D completes.
  -> I is granted on the first IDLE cycle, with m_addr changing only at that grant.
- Reset mid-op: assert rst during SERVE_D with m_write=1.
  -> m_write=0 and all outputs at reset values immediately (asynchronous).
  -> A stray m_resp one cycle after reset release produces no i_resp or d_resp.
- Stray and conflicting: m_resp pulse in IDLE -> no resp; d_read=d_write=1 -> m_write=1 (write wins).

Source files
------------

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin sharing of one cacheline memory port between icache reads and dcache reads/writes
module cache_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              m_read,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_addr,
   output logic [LINE_W-1:0] m_wdata,
   input  logic [LINE_W-1:0] m_rdata,
   input  logic              m_resp
);
   localparam int OFS = $clog2(LINE_W / 8);
   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
   state_t state, state_n;
   logic last_d, last_d_n, m_read_n, m_write_n, i_pend, d_pend, grant_d, wr;
   logic [ADDR_W-1:0] req_addr, m_addr_n;
   logic [LINE_W-1:0] m_wdata_n;
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;
   assign i_resp = (state == SERVE_I) && m_resp;
   assign d_resp = (state == SERVE_D) && m_resp;
   assign i_pend = i_read;
   assign d_pend = d_read || d_write;
   // on a tie the requester that did not win last time gets the port
   assign grant_d = d_pend && (!i_pend || !last_d);
   assign wr = grant_d && d_write;
   assign req_addr = grant_d ? d_addr : i_addr;
   always_comb begin
      state_n = state;
      last_d_n = last_d;
      m_read_n = m_read;
      m_write_n = m_write;
      m_addr_n = m_addr;
      m_wdata_n = m_wdata;
      if (state == IDLE && (i_pend || d_pend)) begin
         state_n = grant_d ? SERVE_D : SERVE_I;
         last_d_n = grant_d;
         m_read_n = !wr;
         m_write_n = wr;
         m_addr_n = {req_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
         m_wdata_n = wr ? d_wdata : m_wdata;
      end else if (state != IDLE && m_resp) begin
         state_n = IDLE;
         m_read_n = 1'b0;
         m_write_n = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last_d <= 1'b0;
         m_read <= 1'b0;
         m_write <= 1'b0;
         m_addr <= '0;
         m_wdata <= '0;
      end else begin
         state <= state_n;
         last_d <= last_d_n;
         m_read <= m_read_n;
         m_write <= m_write_n;
         m_addr <= m_addr_n;
         m_wdata <= m_wdata_n;
      end
   end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed self-checking bench for cache_arbiter
module tb_cache_arbiter;
   logic clk = 0, rst = 1;
   logic i_read = 0, d_read = 0, d_write = 0, m_resp = 0;
   logic [31:0] i_addr = 0, d_addr = 0;
   logic [255:0] d_wdata = 0, m_rdata = 0;
   logic [255:0] i_rdata, d_rdata, m_wdata;
   logic i_resp, d_resp, m_read, m_write;
   logic [31:0] m_addr;
   int checks = 0, errors = 0;
   localparam logic [255:0] AA = {32{8'hAA}};
   localparam logic [255:0] FIVES = {32{8'h55}};
   localparam logic [255:0] PAT = {8{32'h1234_5678}};
   localparam logic [255:0] PAT2 = {8{32'hCAFE_F00D}};

   cache_arbiter dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_resp(m_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic samp;
      @(negedge clk);
   endtask

   initial begin
      m_rdata = PAT;
      tick; tick;
      samp;
      chk("rst_m_read", m_read, 0);
      chk("rst_m_write", m_write, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_i_resp", i_resp, 0);
      chk("rst_d_resp", d_resp, 0);
      chk("rst_i_rdata", i_rdata, PAT);
      chk("rst_d_rdata", d_rdata, PAT);
      tick; rst = 0;
      // lone I read, memory answers three cycles after m_read
      tick; i_read = 1; i_addr = 32'h0000_1234;
      samp; chk("i_not_early", m_read, 0);
      tick; samp;
      chk("i_m_read", m_read, 1);
      chk("i_m_addr", m_addr, 32'h0000_1220);
      chk("i_no_resp_yet", i_resp, 0);
      tick; tick;
      tick; m_resp = 1; m_rdata = AA;
      samp;
      chk("i_resp", i_resp, 1);
      chk("i_rdata", i_rdata, AA);
      chk("i_d_resp0", d_resp, 0);
      tick; m_resp = 0; i_read = 0;
      samp;
      chk("i_done_m_read", m_read, 0);
      chk("i_done_resp", i_resp, 0);
      chk("i_addr_hold", m_addr, 32'h0000_1220);
      // lone D write
      tick; d_write = 1; d_addr = 32'h8000_003C; d_wdata = FIVES;
      tick; samp;
      chk("dw_m_write", m_write, 1);
      chk("dw_m_read", m_read, 0);
      chk("dw_m_addr", m_addr, 32'h8000_0020);
      chk("dw_m_wdata", m_wdata, FIVES);
      tick; m_resp = 1;
      samp;
      chk("dw_d_resp", d_resp, 1);
      chk("dw_i_resp", i_resp, 0);
      chk("dw_no_read", m_read, 0);
      tick; m_resp = 0; d_write = 0; d_wdata = 0;
      samp;
      chk("dw_done", m_write, 0);
      chk("dw_wdata_hold", m_wdata, FIVES);
      // tie after a D grant: I wins, then D
      tick; i_read = 1; d_read = 1; i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
      tick; samp;
      chk("tie1_first_addr", m_addr, 32'h0000_0100);
      chk("tie1_first_read", m_read, 1);
      tick; m_resp = 1; m_rdata = PAT2;
      samp;
      chk("tie1_i_resp", i_resp, 1);
      chk("tie1_d_wait", d_resp, 0);
      chk("tie1_rdata", i_rdata, PAT2);
      chk("tie1_wdata_hold", m_wdata, FIVES);
      tick; m_resp = 0; i_read = 0;
      samp;
      chk("tie1_idle", m_read, 0);
      tick; samp;
      chk("tie1_second_addr", m_addr, 32'h0000_0200);
      chk("tie1_second_read", m_read, 1);
      tick; m_resp = 1;
      samp; chk("tie1_d_resp", d_resp, 1);
      tick; m_resp = 0; d_read = 0;
      // reset, then tie: D wins first
      rst = 1; tick; rst = 0;
      tick; i_read = 1; d_read = 1; i_addr = 32'h0000_0040; d_addr = 32'h0000_0080;
      tick; samp;
      chk("tie0_first_addr", m_addr, 32'h0000_0080);
      tick; tick; m_resp = 1;
      samp;
      chk("tie0_d_resp", d_resp, 1);
      chk("tie0_i_wait", i_resp, 0);
      tick; m_resp = 0; d_read = 0;
      samp; chk("tie0_idle", m_read, 0);
      tick; samp;
      chk("tie0_second_addr", m_addr, 32'h0000_0040);
      tick; tick; m_resp = 1;
      samp; chk("tie0_i_resp", i_resp, 1);
      tick; m_resp = 0; i_read = 0;
      // contention: I rises while D is in service
      tick; d_read = 1; d_addr = 32'h0000_0300;
      tick; samp;
      chk("ct_d_addr", m_addr, 32'h0000_0300);
      tick; i_read = 1; i_addr = 32'h0000_0404; d_addr = 32'h0000_0FFF;
      samp;
      chk("ct_i_wait", i_resp, 0);
      chk("ct_addr_latched", m_addr, 32'h0000_0300);
      tick; m_resp = 1;
      samp;
      chk("ct_d_resp", d_resp, 1);
      chk("ct_i_resp0", i_resp, 0);
      tick; m_resp = 0; d_read = 0;
      samp;
      chk("ct_idle_read", m_read, 0);
      chk("ct_idle_addr", m_addr, 32'h0000_0300);
      tick; samp;
      chk("ct_i_grant_addr", m_addr, 32'h0000_0400);
      chk("ct_i_grant_read", m_read, 1);
      tick; m_resp = 1;
      samp; chk("ct_i_resp", i_resp, 1);
      tick; m_resp = 0; i_read = 0;
      // asynchronous reset mid write
      tick; d_write = 1; d_addr = 32'h0000_0500; d_wdata = PAT;
      tick; samp;
      chk("rm_m_write", m_write, 1);
      #1 rst = 1; d_write = 0;
      #1;
      chk("rm_m_write0", m_write, 0);
      chk("rm_m_addr0", m_addr, 0);
      chk("rm_m_wdata0", m_wdata, 0);
      tick; tick; rst = 0;
      tick; m_resp = 1;
      samp;
      chk("rm_stray_i", i_resp, 0);
      chk("rm_stray_d", d_resp, 0);
      chk("rm_stray_read", m_read, 0);
      tick; m_resp = 0;
      // conflicting read and write: write wins
      tick; d_read = 1; d_write = 1; d_addr = 32'h0000_0610; d_wdata = PAT2;
      tick; samp;
      chk("cf_m_write", m_write, 1);
      chk("cf_m_read", m_read, 0);
      chk("cf_m_addr", m_addr, 32'h0000_0600);
      chk("cf_m_wdata", m_wdata, PAT2);
      tick; m_resp = 1;
      samp; chk("cf_d_resp", d_resp, 1);
      tick; m_resp = 0; d_read = 0; d_write = 0;
      samp; chk("cf_done", m_write, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
